// File: rtl/shape_pkg.sv
// Shared types and constants for the tangram shape editor.
// Enumerations, the shape record and the angle range used by the edit datapath.
package shape_pkg;
  // Integer field width, kept in step with the shared math constants
  localparam int INT_BITS  = 16;
  localparam int COLOR_W   = 12;
  localparam int ANGLE_MIN = -180;
  localparam int ANGLE_MAX = 179;

  typedef enum logic [1:0] {MOVE, TRANSFORM, MANAGE, COLOR} mode_t;
  typedef enum logic [1:0] {IDLE, APPLY, ADVANCE, DONE} state_t;

  typedef struct packed {
    logic [INT_BITS-1:0]        ty;
    logic [INT_BITS-1:0]        x;
    logic [INT_BITS-1:0]        y;
    logic [INT_BITS-1:0]        size;
    logic signed [INT_BITS-1:0] angle;
    logic [COLOR_W-1:0]         color;
  } shape_t;
endpackage

// File: rtl/shape_editor_bounded_step.sv
// Combinational +/- step on one shape field, either saturating at [lo, hi]
// or wrapping around the range (used for the angle).
module bounded_step
  import shape_pkg::*;
#(
  parameter int W = INT_BITS
) (
  input  logic signed [W-1:0] value,
  input  logic        [W-1:0] step,
  input  logic signed [W-1:0] lo,
  input  logic signed [W-1:0] hi,
  input  logic                dir,
  input  logic                wrap_en,
  output logic signed [W-1:0] next
);
  logic signed [W:0] v, s, l, h, span, wide, res;

  always_comb begin
    v    = {value[W-1], value};
    s    = {1'b0, step};
    l    = {lo[W-1], lo};
    h    = {hi[W-1], hi};
    span = h - l + 1'b1;
    wide = dir ? (v + s) : (v - s);
    res  = wide;
    if (wrap_en) begin
      if (wide > h)      res = wide - span;
      else if (wide < l) res = wide + span;
    end else begin
      if (wide > h)      res = h;
      else if (wide < l) res = l;
    end
    next = res[W-1:0];
  end
endmodule

// File: rtl/shape_editor.sv
// Per-frame edit controller: holds the shape attribute file and applies one
// batch of button edits to the selected shape each frame, then pulses done.
module shape_editor
  import shape_pkg::*;
#(
  parameter int MAXSHP   = 4,
  parameter int PIXLW    = 12,
  parameter int SCR_W    = 800,
  parameter int SCR_H    = 600,
  parameter int MAX_SIZE = 255,
  parameter int DEF_SIZE = 10,
  parameter int NTYPE    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame,
  input  logic [1:0]                 mode,
  input  logic                       l_p,
  input  logic                       r_p,
  input  logic                       u_p,
  input  logic                       d_p,
  input  logic                       l_once,
  input  logic                       r_once,
  input  logic                       c_once,
  input  logic [1:0]                 mag,
  input  logic [PIXLW-1:0]           pick_color,
  output logic [INT_BITS-1:0]        s_ty    [MAXSHP],
  output logic [INT_BITS-1:0]        s_x     [MAXSHP],
  output logic [INT_BITS-1:0]        s_y     [MAXSHP],
  output logic [INT_BITS-1:0]        s_size  [MAXSHP],
  output logic signed [INT_BITS-1:0] s_angle [MAXSHP],
  output logic [PIXLW-1:0]           s_color [MAXSHP],
  output logic [INT_BITS-1:0]        sel,
  output logic [INT_BITS-1:0]        count,
  output logic                       done
);
  localparam int IDXW = (MAXSHP > 1) ? $clog2(MAXSHP) : 1;

  state_t                     state;
  logic [IDXW-1:0]            si, ci, li;
  logic [INT_BITS-1:0]        step;
  logic signed [INT_BITS-1:0] nx, ny, nsize, nangle;

  assign si   = sel[IDXW-1:0];
  assign ci   = count[IDXW-1:0];
  assign li   = IDXW'(count - 1'b1);
  assign step = INT_BITS'(1) << mag;

  bounded_step u_x (.value(s_x[si]), .step(step), .lo('0),
    .hi(INT_BITS'(SCR_W-1)), .dir(!l_p), .wrap_en(1'b0), .next(nx));
  bounded_step u_y (.value(s_y[si]), .step(step), .lo('0),
    .hi(INT_BITS'(SCR_H-1)), .dir(!u_p), .wrap_en(1'b0), .next(ny));
  bounded_step u_size (.value(s_size[si]), .step(step), .lo('0),
    .hi(INT_BITS'(MAX_SIZE)), .dir(u_p), .wrap_en(1'b0), .next(nsize));
  bounded_step u_angle (.value(s_angle[si]), .step(step), .lo(INT_BITS'(ANGLE_MIN)),
    .hi(INT_BITS'(ANGLE_MAX)), .dir(!l_p), .wrap_en(1'b1), .next(nangle));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= INT_BITS'(1);
      sel   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < MAXSHP; i++) begin
        s_ty[i]    <= '0;
        s_angle[i] <= '0;
        s_x[i]     <= (i == 0) ? INT_BITS'(SCR_W/2) : '0;
        s_y[i]     <= (i == 0) ? INT_BITS'(SCR_H/2) : '0;
        s_size[i]  <= (i == 0) ? INT_BITS'(DEF_SIZE) : '0;
        s_color[i] <= (i == 0) ? PIXLW'(12'hFFF) : '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (frame) state <= APPLY;
        APPLY: begin
          unique case (mode_t'(mode))
            MOVE: begin
              if (u_p || d_p) s_y[si] <= ny;
              if (l_p || r_p) s_x[si] <= nx;
            end
            TRANSFORM: begin
              if (l_p || r_p) s_angle[si] <= nangle;
              if (u_p || d_p) s_size[si]  <= nsize;
              if (c_once)
                s_ty[si] <= (s_ty[si] >= INT_BITS'(NTYPE-1)) ? '0 : s_ty[si] + 1'b1;
            end
            MANAGE: begin
              if (l_once && count > INT_BITS'(1)) begin
                count       <= count - 1'b1;
                s_color[li] <= '0;
                if (sel == count - 1'b1) sel <= count - INT_BITS'(2);
              end else if (r_once && count < INT_BITS'(MAXSHP)) begin
                s_ty[ci]    <= '0;
                s_x[ci]     <= INT_BITS'(SCR_W/2);
                s_y[ci]     <= INT_BITS'(SCR_H/2);
                s_size[ci]  <= INT_BITS'(DEF_SIZE);
                s_angle[ci] <= '0;
                s_color[ci] <= PIXLW'(12'hFFF);
                count       <= count + 1'b1;
              end
            end
            COLOR: if (c_once) s_color[si] <= pick_color;
            default: ;
          endcase
          // Selection advance happens a cycle later so it sees the updated count
          if (mode_t'(mode) == MANAGE && c_once) begin
            state <= ADVANCE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        ADVANCE: begin
          sel   <= (sel + 1'b1 >= count) ? '0 : sel + 1'b1;
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/shape_editor.md
# shape_editor

Per-frame edit controller for the tangram scene. It holds the attribute register file for up to MAXSHP shapes: type, position, size, angle and colour. Once per VGA frame it applies one batch of button-driven edits to the currently selected shape, then pulses `done` so the button input latches clear. It is the multi-shape, parametrised successor of the single-shape edit logic. It drives the `render_shape` array and the pixel selector, and also feeds the seven-segment readout.

## Interface
Parameters:
- `MAXSHP`, 4: number of shape slots.
- `PIXLW`, 12: colour width in bits (4:4:4 RGB).
- `SCR_W`, 800: screen width; x is clamped to 0..SCR_W-1.
- `SCR_H`, 600: screen height; y is clamped to 0..SCR_H-1.
- `MAX_SIZE`, 255: upper bound on size.
- `DEF_SIZE`, 10: size given to a newly created shape.
- `NTYPE`, 4: number of shape types.

Ports (clock and reset first):
- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high.
- `frame`  in  1: one-cycle pulse at the start of vertical blank.
- `mode`  in  2: 0 MOVE, 1 TRANSFORM, 2 MANAGE, 3 COLOR.
- `l_p`, `r_p`, `u_p`, `d_p`  in  1 each: held-button requests.
- `l_once`, `r_once`, `c_once`  in  1 each: single-shot requests.
- `mag`  in  2: step magnitude; step = 1 << mag, giving 1, 2, 4 or 8.
- `pick_color`  in  PIXLW: colour from the colour map.
- `s_ty[MAXSHP]`, `s_x[MAXSHP]`, `s_y[MAXSHP]`, `s_size[MAXSHP]`  out  INT_BITS each.
- `s_angle[MAXSHP]`  out  INT_BITS, signed.
- `s_color[MAXSHP]`  out  PIXLW.
- `sel`  out  INT_BITS: index of the selected shape.
- `count`  out  INT_BITS: number of active shapes.
- `done`  out  1: end-of-update pulse.

## Operation
- State machine: IDLE, APPLY, ADVANCE, DONE.
  - IDLE goes to APPLY when `frame` is high; otherwise it stays in IDLE.
  - APPLY goes to ADVANCE when mode = 2 and `c_once` is high; otherwise it goes to DONE.
  - ADVANCE goes to DONE.
  - DONE goes to IDLE.
- All edits target slot `sel`. `mode` and every request input are sampled only in APPLY.
- Simultaneous requests: `u` beats `d`, and `l` beats `r`.
- MOVE:
  - `u_p` / `d_p`: y -= step / y += step, saturating at 0 and SCR_H-1.
  - `l_p` / `r_p`: x -= step / x += step, saturating at 0 and SCR_W-1.
- TRANSFORM:
  - `l_p` / `r_p`: angle -= step / angle += step, wrapping within [-180, 179]. A result above 179 has 360 subtracted; a result below -180 has 360 added.
  - `u_p` / `d_p`: size += step / size -= step, saturating at 0 and MAX_SIZE.
  - `c_once`: ty increments and wraps from NTYPE-1 to 0.
- MANAGE:
  - `l_once` with count > 1 removes the last shape: count -= 1, and that slot's colour is set to 0. If sel was that slot, sel becomes count-2.
  - `r_once` with count < MAXSHP adds a shape in slot `count`: colour 12'hFFF, x = SCR_W/2, y = SCR_H/2, size = DEF_SIZE, angle 0, type 0; then count += 1.
  - `l_once` takes priority over `r_once`.
  - In ADVANCE, sel = sel+1, wrapping to 0 at count.
- COLOR: `c_once` sets s_color[sel] to `pick_color`.
- Arithmetic: computed at INT_BITS+1 bits, then clamped or wrapped before writeback. A request at its bound leaves the value unchanged.

## Timing
- Reset values:
  - State IDLE, count = 1, sel = 0, done = 0.
  - Slot 0: x = SCR_W/2, y = SCR_H/2, size = DEF_SIZE, angle 0, type 0, colour 12'hFFF.
  - All other slots: all fields 0.
- Latency: with `frame` high in cycle 0 while in IDLE, the edit is registered at the end of cycle 1.
  - `done` is high in cycle 2, or in cycle 3 when ADVANCE runs.
  - `done` is exactly one cycle wide.
- A `frame` pulse arriving outside IDLE is ignored. At most one edit batch is applied per frame.
- `rst` in any state restores all reset values on the next edge and cancels any pending edit.
- Outputs are registered and stable between updates, so they are safe to read from the pixel clock domain (the same clock).

## Structure
- Package `shape_pkg` holds:
  - `mode_t` enum (MOVE, TRANSFORM, MANAGE, COLOR);
  - `state_t` enum;
  - `shape_t` struct (ty, x, y, size, angle, color);
  - the angle bounds -180 and 179.
- INT_BITS continues to come from the math constants header.
- Sub-module `bounded_step` is combinational: inputs value, step, lo, hi, dir, wrap_en; output next value. It is instantiated once per field: x, y, size and angle.
- The existing `circular_step` is superseded for this block.

## Test plan
- Reset: count = 1, sel = 0, s_x[0] = 400, s_y[0] = 300, s_color[0] = FFF, s_color[1] = 0.
- MOVE with mag = 3, `u_p` held, s_y[0] = 5: after one frame y = 0, and after a second frame y is still 0. With `u_p` and `d_p` together from y = 300, the result is y = 292.
- TRANSFORM with angle 176, mag = 2, `r_p`: angle becomes -180. Then `l_p` with mag = 0: angle becomes 179.
- MANAGE:
  - `r_once` three times: count = 4, s_color[3] = FFF.
  - A fourth `r_once`: count stays 4.
  - `c_once` from sel = 3: sel = 0, and `done` lands at cycle 3.
- MANAGE remove with sel = 3: `l_once` gives count = 3, sel = 2, s_color[3] = 0.
- COLOR: `c_once` with pick_color = 12'h0F0 and sel = 2 gives s_color[2] = 0F0, with the other slots unchanged. `rst` asserted during APPLY: no edit is applied and reset values are restored.
